fir_decim_out: RTL

FIR_DECIM_OUT -- requirements
Module: fir_decim_out

---
 rtl/fir_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/fir_decim_out.sv | 104 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths, default parameters and the output clamp for the FIR decimator.
package fir_pkg;

    localparam int SAMPLE_W  = 32;
    localparam int DECIM_DEF = 4;
    localparam int SHIFT_DEF = 2;
    localparam int OUT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;
    // Wide enough for a 16-sample sum plus the rounding carry.
    localparam int WIDE_W    = 40;

    function automatic logic signed [WIDE_W-1:0] saturate(
        input logic signed [WIDE_W-1:0] v,
        input int                       out_w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = '0;
        for (int i = 0; i < WIDE_W; i++) begin
            if (i < out_w - 1) hi[i] = 1'b1;
        end
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = cnt_q;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// Sums DECIM accepted samples, rounds/shifts, saturates to OUT_W and queues results.
// Result appears at the FIFO head two edges after the last sample of a group is driven.
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int DECIM = DECIM_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [SAMPLE_W-1:0]  y_in,
    input  logic                        in_valid,
    output logic signed [OUT_W-1:0]     out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat,
    output logic                        ovf,
    input  logic                        clr_flags,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int PH_W  = $clog2(DECIM);
    localparam int ACC_W = SAMPLE_W + $clog2(DECIM);
    localparam int RND_W = ACC_W + 1;
    localparam logic signed [RND_W-1:0] HALF = RND_W'(2 ** (SHIFT - 1));

    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
    logic                    sum_vld_q, sum_vld_d;
    logic                    sat_q, sat_d, ovf_q, ovf_d;

    logic signed [ACC_W-1:0]  y_ext;
    logic signed [RND_W-1:0]  rounded;
    logic signed [WIDE_W-1:0] wide, clamped;
    logic [OUT_W-1:0]         res;
    logic                     fifo_full, fifo_empty, pop, sat_evt, ovf_evt;

    assign y_ext = ACC_W'(y_in);

    always_comb begin
        phase_d   = phase_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        sum_vld_d = 1'b0;
        if (in_valid) begin
            acc_d = (phase_q == '0) ? y_ext : acc_q + y_ext;
            if (phase_q == PH_W'(DECIM - 1)) begin
                phase_d   = '0;
                sum_d     = acc_q + y_ext;
                sum_vld_d = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Extra bit so the rounding constant cannot wrap a maximal positive sum.
    assign rounded = (RND_W'(sum_q) + HALF) >>> SHIFT;
    assign wide    = WIDE_W'(rounded);
    assign clamped = saturate(wide, OUT_W);
    assign res     = clamped[OUT_W-1:0];

    assign pop     = out_valid && out_ready;
    assign sat_evt = sum_vld_q && (clamped != wide);
    assign ovf_evt = sum_vld_q && fifo_full && !pop;
    assign sat_d   = (sat_q && !clr_flags) || sat_evt;
    assign ovf_d   = (ovf_q && !clr_flags) || ovf_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sum_vld_q),
        .pop   (pop),
        .din   (res),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid = !fifo_empty;
    assign sat       = sat_q;
    assign ovf       = ovf_q;

endmodule
